uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Frame controller sitting directly behind the UART byte receiver. It consumes the receiver's byte-valid strobe and data byte, and parses sync/command/length/payload/checksum frames. Good frames are buffered and presented to the host logic through a valid/ack handshake. Bad, late or overrun frames are discarded and counted.

Parameters:
MAX_PAYLOAD, 16, max payload bytes per frame (1..255)
ADDR_W, 4, payload buffer address width; 2**ADDR_W >= MAX_PAYLOAD
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLKS, 86800, max idle clocks between bytes inside a frame (10 byte times at 868 clks/bit)

Ports:
i_Clock  in  1  system clock
i_Reset_N  in  1  asynchronous active-low reset
i_Rx_DV  in  1  one-cycle strobe, byte valid from UART receiver
i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1
o_Frame_Valid  out  1  good frame pending
i_Frame_Ack  in  1  host releases pending frame
o_Frame_Cmd  out  8  command byte of pending frame
o_Frame_Len  out  8  payload length of pending frame
i_Rd_Addr  in  ADDR_W  payload buffer read address
o_Rd_Data  out  8  buffer[i_Rd_Addr], registered, 1-cycle latency
o_Busy  out  1  high in any state other than IDLE
o_Err_Chk_Cnt  out  8  saturating checksum-error count
o_Err_Len_Cnt  out  8  saturating length-error count
o_Err_Tmo_Cnt  out  8  saturating timeout count
o_Err_Ovr_Cnt  out  8  saturating overrun count

Behaviour:
- Clock/reset: single clock i_Clock; reset asynchronous, active-low on i_Reset_N.
- Reset (async, any state, mid-frame included): state=IDLE. All outputs and counters 0. Checksum accumulator, byte index and timeout counter 0. Buffer contents undefined.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes. No escaping; SYNC_BYTE inside a frame is plain data.
- IDLE: on i_Rx_DV with byte==SYNC_BYTE -> CMD. Any other byte is discarded silently and not counted.
- CMD: on DV, latch cmd, acc=byte -> LEN.
- LEN: on DV, latch len, acc^=byte. If len>MAX_PAYLOAD: Err_Len++ -> IDLE. Else if len==0 -> CHECK. Else index=0 -> PAYLOAD.
- PAYLOAD: on DV, buffer[index]=byte, acc^=byte, index++. Leave for CHECK when index reaches len.
- CHECK: on DV, compare byte with acc. Match -> HOLD, with o_Frame_Valid=1 from the next cycle. Mismatch -> Err_Chk++ -> IDLE.
- Timeout: in CMD/LEN/PAYLOAD/CHECK the counter increments every cycle and clears on each DV. If it reaches TIMEOUT_CLKS-1 with no DV: Err_Tmo++ -> IDLE. If a DV arrives in the same cycle the counter would expire, the byte wins and no timeout occurs. The counter is held at 0 in IDLE and HOLD.
- HOLD: o_Frame_Cmd, o_Frame_Len and the buffer are frozen; no buffer writes. Every DV in HOLD is dropped and increments Err_Ovr, sync bytes included.
- Ack: i_Frame_Ack in HOLD -> IDLE; o_Frame_Valid is low the next cycle. A DV in the same cycle as the ack is still dropped and counted as overrun. Ack outside HOLD is ignored.
- Cmd/Len outputs hold their last frame's values after ack until the next good frame completes.
- Read port: o_Rd_Data updates every cycle regardless of state. Its contents are guaranteed only while o_Frame_Valid=1 and addr<len.
- Counters saturate at 8'hFF, never wrap. All error increments take effect one cycle after the causing event.

Decomposition:
- Shared package uart_frame_pkg:
  - state enum: IDLE, CMD, LEN, PAYLOAD, CHECK, HOLD (3-bit encoding)
  - default SYNC_BYTE
  - error counter width (8)
- Sub-module sat_cnt: 8-bit saturating counter with inc enable and async active-low reset. Instantiated four times.
- Payload buffer is inferred inline as a synchronous-read register array.

Test Plan:
- Good frame: A5 01 02 10 20 33 -> o_Frame_Valid=1 the cycle after CHK, Cmd=01, Len=02, addr0->10, addr1->20, all counters 0. Ack -> Valid=0 next cycle, o_Busy=0.
- Bad checksum: A5 01 02 10 20 34 -> Valid stays 0, Err_Chk_Cnt=1, state IDLE. Then a good frame A5 07 00 07 -> Valid=1, Cmd=07, Len=00.
- Length error: A5 01 11 (MAX_PAYLOAD=16) -> Err_Len_Cnt=1, no valid. Following bytes 5A 11 are ignored in IDLE, counters unchanged.
- Timeout (TIMEOUT_CLKS=100): A5 01, then 100 idle clocks -> Err_Tmo_Cnt=1, o_Busy=0. Repeat with a DV on the 99th idle cycle -> no timeout.
- Overrun: good frame not acked, then A5 02 00 02 -> Err_Ovr_Cnt=4, Cmd/Len/buffer unchanged. Ack with a simultaneous DV -> Err_Ovr_Cnt=5, Valid=0.
- Reset mid-payload: A5 01 04 AA, then i_Reset_N low 3 cycles -> all outputs 0. A subsequent good frame is accepted normally.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame controller.
// Contents: frame parser state encoding, default sync marker and the
// width of the saturating error counters.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         ERR_CNT_W     = 8;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter used for the frame error statistics.
// Ports: clk/rst_n (async active-low), inc (count enable), cnt (value,
// sticks at all-ones instead of wrapping).
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART byte receiver.
// Parses SYNC, CMD, LEN, payload, CHK frames (CHK = XOR of CMD, LEN and
// payload), buffers good frames and presents them to the host with a
// valid/ack handshake. Bad, late and overrun frames are discarded and
// counted in four saturating counters.
// Ports: i_Clock/i_Reset_N clock and async active-low reset;
// i_Rx_DV/i_Rx_Byte byte strobe and data from the receiver;
// o_Frame_Valid/i_Frame_Ack host handshake; o_Frame_Cmd/o_Frame_Len header
// of the pending frame; i_Rd_Addr/o_Rd_Data payload read port (1-cycle
// latency); o_Busy parser not idle; o_Err_*_Cnt error statistics.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_PAYLOAD  = 16,
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 86800
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_N,
    input  logic                 i_Rx_DV,
    input  logic [7:0]           i_Rx_Byte,
    output logic                 o_Frame_Valid,
    input  logic                 i_Frame_Ack,
    output logic [7:0]           o_Frame_Cmd,
    output logic [7:0]           o_Frame_Len,
    input  logic [ADDR_W-1:0]    i_Rd_Addr,
    output logic [7:0]           o_Rd_Data,
    output logic                 o_Busy,
    output logic [ERR_CNT_W-1:0] o_Err_Chk_Cnt,
    output logic [ERR_CNT_W-1:0] o_Err_Len_Cnt,
    output logic [ERR_CNT_W-1:0] o_Err_Tmo_Cnt,
    output logic [ERR_CNT_W-1:0] o_Err_Ovr_Cnt
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN  = 8'(MAX_PAYLOAD);

    frame_state_t     state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;       // header of the frame in flight
    logic [7:0]       len_q, len_d;
    logic [7:0]       out_cmd_q, out_cmd_d; // header of the last good frame
    logic [7:0]       out_len_q, out_len_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       rd_data_q;
    logic             buf_we_s;
    logic             chk_inc_s, len_inc_s, tmo_inc_s, ovr_inc_s;

    logic [7:0] pay_mem [2**ADDR_W];

    // Parser next-state, datapath updates and error pulses.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        out_cmd_d = out_cmd_q;
        out_len_d = out_len_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        tmo_d     = {TMO_W{1'b0}};
        buf_we_s  = 1'b0;
        chk_inc_s = 1'b0;
        len_inc_s = 1'b0;
        tmo_inc_s = 1'b0;
        ovr_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Bytes arriving while a frame is pending are lost, even on
                // the ack cycle itself.
                ovr_inc_s = i_Rx_DV;
                if (i_Frame_Ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                if (i_Rx_DV) begin
                    // A byte on the expiry cycle still wins over the timeout.
                    tmo_d = {TMO_W{1'b0}};
                    case (state_q)
                        ST_CMD: begin
                            cmd_d   = i_Rx_Byte;
                            acc_d   = i_Rx_Byte;
                            state_d = ST_LEN;
                        end
                        ST_LEN: begin
                            len_d = i_Rx_Byte;
                            acc_d = acc_q ^ i_Rx_Byte;
                            idx_d = 8'd0;
                            if (i_Rx_Byte > MAX_LEN) begin
                                len_inc_s = 1'b1;
                                state_d   = ST_IDLE;
                            end else if (i_Rx_Byte == 8'd0) begin
                                state_d = ST_CHECK;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            buf_we_s = 1'b1;
                            acc_d    = acc_q ^ i_Rx_Byte;
                            idx_d    = idx_q + 8'd1;
                            if ((idx_q + 8'd1) == len_q) begin
                                state_d = ST_CHECK;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                        ST_CHECK: begin
                            if (i_Rx_Byte == acc_q) begin
                                out_cmd_d = cmd_q;
                                out_len_d = len_q;
                                state_d   = ST_HOLD;
                            end else begin
                                chk_inc_s = 1'b1;
                                state_d   = ST_IDLE;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    tmo_inc_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Parser state and datapath registers.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q   <= ST_IDLE;
            cmd_q     <= 8'd0;
            len_q     <= 8'd0;
            out_cmd_q <= 8'd0;
            out_len_q <= 8'd0;
            acc_q     <= 8'd0;
            idx_q     <= 8'd0;
            tmo_q     <= {TMO_W{1'b0}};
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            out_cmd_q <= out_cmd_d;
            out_len_q <= out_len_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            rd_data_q <= pay_mem[i_Rd_Addr];
        end
    end

    // Payload storage; contents are don't-care after reset so it has none.
    always_ff @(posedge i_Clock) begin
        if (buf_we_s) begin
            pay_mem[idx_q[ADDR_W-1:0]] <= i_Rx_Byte;
        end else begin
            pay_mem[idx_q[ADDR_W-1:0]] <= pay_mem[idx_q[ADDR_W-1:0]];
        end
    end

    sat_cnt #(.W(ERR_CNT_W)) u_cnt_chk (
        .clk(i_Clock), .rst_n(i_Reset_N), .inc(chk_inc_s), .cnt(o_Err_Chk_Cnt)
    );
    sat_cnt #(.W(ERR_CNT_W)) u_cnt_len (
        .clk(i_Clock), .rst_n(i_Reset_N), .inc(len_inc_s), .cnt(o_Err_Len_Cnt)
    );
    sat_cnt #(.W(ERR_CNT_W)) u_cnt_tmo (
        .clk(i_Clock), .rst_n(i_Reset_N), .inc(tmo_inc_s), .cnt(o_Err_Tmo_Cnt)
    );
    sat_cnt #(.W(ERR_CNT_W)) u_cnt_ovr (
        .clk(i_Clock), .rst_n(i_Reset_N), .inc(ovr_inc_s), .cnt(o_Err_Ovr_Cnt)
    );

    assign o_Frame_Valid = (state_q == ST_HOLD);
    assign o_Busy        = (state_q != ST_IDLE);
    assign o_Frame_Cmd   = out_cmd_q;
    assign o_Frame_Len   = out_len_q;
    assign o_Rd_Data     = rd_data_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (MAX_PAYLOAD=16, TIMEOUT_CLKS=100).
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       valid, busy;
    logic [7:0] cmd, len, rd_data;
    logic [7:0] e_chk, e_len, e_tmo, e_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_frame_ctrl #(
        .MAX_PAYLOAD(16), .ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(100)
    ) dut (
        .i_Clock(clk), .i_Reset_N(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .o_Frame_Valid(valid), .i_Frame_Ack(ack), .o_Frame_Cmd(cmd),
        .o_Frame_Len(len), .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data),
        .o_Busy(busy), .o_Err_Chk_Cnt(e_chk), .o_Err_Len_Cnt(e_len),
        .o_Err_Tmo_Cnt(e_tmo), .o_Err_Ovr_Cnt(e_ovr)
    );

    always #5 clk = ~clk;

    // Present one byte for one cycle; returns at the falling edge after it was taken.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic read_buf(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %h want 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_cmp++; if ({cmd, len, rd_data} !== 24'h0) begin n_bad++; $display("FAIL reset_hdr: got %h want 000000", {cmd, len, rd_data}); end
        n_cmp++; if ({e_chk, e_len, e_tmo, e_ovr} !== 32'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 00000000", {e_chk, e_len, e_tmo, e_ovr}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] d;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL good_valid: got %h want 1", valid); end
        n_cmp++; if (cmd !== 8'h01) begin n_bad++; $display("FAIL good_cmd: got %h want 01", cmd); end
        n_cmp++; if (len !== 8'h02) begin n_bad++; $display("FAIL good_len: got %h want 02", len); end
        read_buf(4'd0, d);
        n_cmp++; if (d !== 8'h10) begin n_bad++; $display("FAIL good_buf0: got %h want 10", d); end
        read_buf(4'd1, d);
        n_cmp++; if (d !== 8'h20) begin n_bad++; $display("FAIL good_buf1: got %h want 20", d); end
        n_cmp++; if ({e_chk, e_len, e_tmo, e_ovr} !== 32'h0) begin n_bad++; $display("FAIL good_cnt: got %h want 00000000", {e_chk, e_len, e_tmo, e_ovr}); end
        do_ack();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL good_ack_valid: got %h want 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good_ack_busy: got %h want 0", busy); end
    endtask

    task automatic test_bad_checksum();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h34);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL chk_valid: got %h want 0", valid); end
        n_cmp++; if (e_chk !== 8'd1) begin n_bad++; $display("FAIL chk_cnt: got %0d want 1", e_chk); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL chk_busy: got %h want 0", busy); end
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL zero_len_valid: got %h want 1", valid); end
        n_cmp++; if ({cmd, len} !== 16'h0700) begin n_bad++; $display("FAIL zero_len_hdr: got %h want 0700", {cmd, len}); end
        do_ack();
    endtask

    task automatic test_length_error();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
        n_cmp++; if (e_len !== 8'd1) begin n_bad++; $display("FAIL len_cnt: got %0d want 1", e_len); end
        n_cmp++; if ({valid, busy} !== 2'b00) begin n_bad++; $display("FAIL len_state: got %b want 00", {valid, busy}); end
        send_byte(8'h5A); send_byte(8'h11);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_junk_busy: got %h want 0", busy); end
        n_cmp++; if ({e_chk, e_len, e_tmo, e_ovr} !== 32'h01010000) begin n_bad++; $display("FAIL idle_junk_cnt: got %h want 01010000", {e_chk, e_len, e_tmo, e_ovr}); end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h01);
        repeat (99) @(negedge clk);
        n_cmp++; if ({busy, e_tmo} !== 9'h100) begin n_bad++; $display("FAIL tmo_early: got %h want 100", {busy, e_tmo}); end
        @(negedge clk);
        n_cmp++; if (e_tmo !== 8'd1) begin n_bad++; $display("FAIL tmo_cnt: got %0d want 1", e_tmo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy: got %h want 0", busy); end
        // Second attempt: LEN byte lands on the 99th idle cycle.
        send_byte(8'hA5); send_byte(8'h01);
        repeat (98) @(negedge clk);
        send_byte(8'h02);
        n_cmp++; if ({busy, e_tmo} !== 9'h101) begin n_bad++; $display("FAIL tmo_edge: got %h want 101", {busy, e_tmo}); end
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
        n_cmp++; if ({valid, cmd, len} !== 17'h10102) begin n_bad++; $display("FAIL tmo_edge_frame: got %h want 10102", {valid, cmd, len}); end
        do_ack();
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h57);
        n_cmp++; if ({valid, cmd, len} !== 17'h10301) begin n_bad++; $display("FAIL ovr_frame: got %h want 10301", {valid, cmd, len}); end
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
        n_cmp++; if (e_ovr !== 8'd4) begin n_bad++; $display("FAIL ovr_cnt: got %0d want 4", e_ovr); end
        n_cmp++; if ({valid, cmd, len} !== 17'h10301) begin n_bad++; $display("FAIL ovr_hold_hdr: got %h want 10301", {valid, cmd, len}); end
        read_buf(4'd0, d);
        n_cmp++; if (d !== 8'h55) begin n_bad++; $display("FAIL ovr_hold_buf: got %h want 55", d); end
        @(negedge clk);
        ack = 1'b1; rx_dv = 1'b1; rx_byte = 8'hA5;
        @(negedge clk);
        ack = 1'b0; rx_dv = 1'b0;
        n_cmp++; if (e_ovr !== 8'd5) begin n_bad++; $display("FAIL ovr_ack_cnt: got %0d want 5", e_ovr); end
        n_cmp++; if ({valid, busy} !== 2'b00) begin n_bad++; $display("FAIL ovr_ack_state: got %b want 00", {valid, busy}); end
        n_cmp++; if ({cmd, len} !== 16'h0301) begin n_bad++; $display("FAIL ovr_ack_hdr: got %h want 0301", {cmd, len}); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04); send_byte(8'hAA);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %h want 1", busy); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({valid, busy, cmd, len, rd_data} !== 26'h0) begin n_bad++; $display("FAIL mid_rst_out: got %h want 0", {valid, busy, cmd, len, rd_data}); end
        n_cmp++; if ({e_chk, e_len, e_tmo, e_ovr} !== 32'h0) begin n_bad++; $display("FAIL mid_rst_cnt: got %h want 00000000", {e_chk, e_len, e_tmo, e_ovr}); end
        rst_n = 1'b1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
        n_cmp++; if ({valid, cmd, len} !== 17'h10102) begin n_bad++; $display("FAIL post_rst_frame: got %h want 10102", {valid, cmd, len}); end
        read_buf(4'd1, d);
        n_cmp++; if (d !== 8'h20) begin n_bad++; $display("FAIL post_rst_buf1: got %h want 20", d); end
        do_ack();
        n_cmp++; if ({valid, busy} !== 2'b00) begin n_bad++; $display("FAIL post_rst_ack: got %b want 00", {valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_length_error();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
